// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer for an external combinational ALU_16bit: single-pass
// registered ALU ops and a 16x16 unsigned shift-and-add multiply.
module alu_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  cmd,
    input  logic [3:0]  op_s,
    input  logic        op_m,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] result,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_s,
    output logic        alu_m,
    input  logic [15:0] alu_f
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SINGLE,
        S_MUL,
        S_DONE,
        S_ERR
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [15:0] r_opa;
    logic [15:0] r_opb;
    logic [3:0]  r_s;
    logic        r_m;
    logic [15:0] r_mcand;
    logic [15:0] r_acc_hi;
    logic [15:0] r_acc_lo;
    logic [3:0]  r_cnt;
    logic [31:0] r_result;

    logic        w_carry;
    logic [15:0] w_sum;
    logic [31:0] w_prod;

    // ALU_16bit has no carry-out; an unsigned wrap of acc_hi+mcand shows as sum < acc_hi.
    assign w_carry = r_acc_lo[0] & (alu_f < r_acc_hi);
    assign w_sum   = r_acc_lo[0] ? alu_f : r_acc_hi;
    assign w_prod  = {w_carry, w_sum, r_acc_lo[15:1]};

    assign result  = r_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b1;
        done         = 1'b0;
        err          = 1'b0;
        alu_a        = '0;
        alu_b        = '0;
        alu_s        = '0;
        alu_m        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    case (cmd)
                        2'b00:   w_next_state = S_SINGLE;
                        2'b01:   w_next_state = S_MUL;
                        default: w_next_state = S_ERR;
                    endcase
                end
            end
            S_SINGLE: begin
                alu_a        = r_opa;
                alu_b        = r_opb;
                alu_s        = r_s;
                alu_m        = r_m;
                w_next_state = S_DONE;
            end
            S_MUL: begin
                alu_a = r_acc_hi;
                alu_b = r_mcand;
                alu_s = 4'b1001;
                alu_m = 1'b0;
                if (r_cnt == 4'd15) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            S_ERR: begin
                err          = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_s      <= '0;
            r_m      <= 1'b0;
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && cmd == 2'b00) begin
                        r_opa <= op_a;
                        r_opb <= op_b;
                        r_s   <= op_s;
                        r_m   <= op_m;
                    end else if (start && cmd == 2'b01) begin
                        r_mcand  <= op_a;
                        r_acc_lo <= op_b;
                        r_acc_hi <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_SINGLE: r_result <= {16'h0000, alu_f};
                S_MUL: begin
                    {r_acc_hi, r_acc_lo} <= w_prod;
                    r_cnt                <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_result <= w_prod;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with a behavioural ALU_16bit stand-in (subset of
// 74181-style functions); table-driven ops plus multi-cycle corner cases.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  cmd;
    logic [3:0]  op_s;
    logic        op_m;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] result;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_s;
    logic        alu_m;
    logic [15:0] alu_f;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .cmd(cmd), .op_s(op_s), .op_m(op_m),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .err(err),
        .result(result), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_m(alu_m), .alu_f(alu_f)
    );

    always_comb begin
        case ({alu_m, alu_s})
            5'b1_0000: alu_f = ~alu_a;
            5'b0_1001: alu_f = alu_a + alu_b;
            5'b1_1011: alu_f = alu_a & alu_b;
            5'b1_1110: alu_f = alu_a | alu_b;
            5'b1_0110: alu_f = alu_a ^ alu_b;
            default:   alu_f = '0;
        endcase
    end

    typedef struct {
        logic [1:0]  cmd;
        logic [3:0]  s;
        logic        m;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input vec_t v);
        int lat;
        bit seen;
        bit busy_ok;
        start = 1'b1; cmd = v.cmd; op_s = v.s; op_m = v.m; op_a = v.a; op_b = v.b;
        step();
        start = 1'b0;
        op_a  = 16'hDEAD; op_b = 16'hBEEF; op_s = 4'hF; op_m = ~v.m;
        if (v.cmd == 2'b01) begin
            chk("mul_alu_s", {28'd0, alu_s}, 32'd9);
            chk("mul_alu_b", {16'd0, alu_b}, {16'd0, v.a});
        end else begin
            chk("single_alu_s", {28'd0, alu_s}, {28'd0, v.s});
            chk("single_alu_a", {16'd0, alu_a}, {16'd0, v.a});
        end
        lat = 0; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            step();
            lat++;
            if (done) seen = 1'b1;
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        chk("latency", lat, v.lat);
        chk("result", result, v.res);
        chk("busy_hold", {31'd0, busy_ok & busy}, 32'd1);
        step();
        chk("idle_after", {29'd0, busy, done, err}, 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        int lat;
        bit seen;
        bit busy_ok;

        vecs[0] = '{2'b00, 4'b0000, 1'b1, 16'h00FF, 16'h0000, 32'h0000FF00, 1};
        vecs[1] = '{2'b00, 4'b1001, 1'b0, 16'h1234, 16'h0001, 32'h00001235, 1};
        vecs[2] = '{2'b00, 4'b1011, 1'b1, 16'h0F0F, 16'h00FF, 32'h0000000F, 1};
        vecs[3] = '{2'b00, 4'b0110, 1'b1, 16'hAAAA, 16'hFFFF, 32'h00005555, 1};
        vecs[4] = '{2'b01, 4'b0000, 1'b0, 16'h0003, 16'h0005, 32'h0000000F, 16};
        vecs[5] = '{2'b01, 4'b0000, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16};
        vecs[6] = '{2'b01, 4'b0000, 1'b0, 16'h0000, 16'h1234, 32'h00000000, 16};
        vecs[7] = '{2'b01, 4'b0000, 1'b0, 16'h1234, 16'h5678, 32'h06260060, 16};
        vecs[8] = '{2'b01, 4'b0000, 1'b0, 16'h00FF, 16'h0100, 32'h0000FF00, 16};
        vecs[9] = '{2'b01, 4'b0000, 1'b0, 16'hFFFF, 16'h0001, 32'h0000FFFF, 16};

        rst = 1'b1; start = 1'b0; cmd = '0; op_s = '0; op_m = 1'b0; op_a = '0; op_b = '0;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("reset_idle", {busy, done, err, alu_s, result[26:0]}, 32'd0);
        end

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i]);
        end

        // Multiply with a stray start mid-operation and another during DONE.
        start = 1'b1; cmd = 2'b01; op_a = 16'h8000; op_b = 16'h0002;
        step();
        start = 1'b0;
        lat = 0; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            if (lat == 4) begin
                start = 1'b1; cmd = 2'b00; op_m = 1'b1; op_s = 4'b0000; op_a = 16'h0000;
            end else begin
                start = 1'b0;
            end
            step();
            lat++;
            if (done) seen = 1'b1;
        end
        chk("ovl_latency", lat, 16);
        chk("ovl_result", result, 32'h00010000);
        chk("ovl_busy_hold", {31'd0, busy_ok}, 32'd1);
        start = 1'b1; cmd = 2'b00;
        step();
        start = 1'b0;
        chk("start_in_done_ignored", {31'd0, busy}, 32'd0);
        step();
        chk("still_idle", {30'd0, busy, done}, 32'd0);
        chk("ovl_result_held", result, 32'h00010000);

        // Asynchronous reset mid-multiply, then an illegal command.
        start = 1'b1; cmd = 2'b01; op_a = 16'h0003; op_b = 16'h0005;
        step();
        start = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        #1;
        chk("rst_ctrl", {29'd0, busy, done, err}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_alu", {alu_a, alu_b[10:0], alu_s, alu_m}, 32'd0);
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (done || busy) seen = 1'b1;
        end
        chk("no_done_after_abort", {31'd0, seen}, 32'd0);
        start = 1'b1; cmd = 2'b11;
        step();
        start = 1'b0;
        chk("err_pulse", {29'd0, busy, done, err}, 32'd5);
        chk("err_result", result, 32'd0);
        step();
        chk("err_cleared", {29'd0, busy, done, err}, 32'd0);
        chk("err_result_held", result, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
